// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared op/state encodings for the sequential ALU.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'b000,
        OP_XOR  = 3'b001,
        OP_ADD  = 3'b010,
        OP_ROTL = 3'b011,
        OP_SUB  = 3'b100,
        OP_MOD  = 3'b101,
        OP_DIV  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_ITER = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    // Ops that go through the shift-subtract loop (when the divisor is non-zero).
    function automatic logic is_iterative(input op_e f_op);
        return (f_op == OP_MOD) || (f_op == OP_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_divstep.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_divstep
// Brief    : One combinational restoring-division step on {rem, quo}.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_divstep #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);

    logic [WIDTH:0]   w_shift;
    logic             w_ge;
    logic [WIDTH-1:0] w_trial;

    // rem < b before the shift, so the shifted value needs one extra bit
    // but a successful trial difference always fits back into WIDTH bits.
    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_ge    = (w_shift >= {1'b0, i_b});
    assign w_trial = w_shift[WIDTH-1:0] - i_b;

    assign o_rem = w_ge ? w_trial : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq
// Brief    : Multi-cycle ALU with start/done handshake and iterative MOD/DIV.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             err
);

    localparam int              c_CNT_W    = $clog2(WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = ST_IDLE;
    localparam logic [1:0] c_EXEC = ST_EXEC;
    localparam logic [1:0] c_ITER = ST_ITER;
    localparam logic [1:0] c_DONE = ST_DONE;

    logic [1:0]         r_state;
    op_e                r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [c_CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0]   r_result;
    logic               r_carry;
    logic               r_zero;
    logic               r_err;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_sc_res;
    logic               w_sc_carry;
    logic               w_sc_err;
    logic               w_div0;
    logic               w_iter;
    logic [WIDTH-1:0]   w_rem_nxt;
    logic [WIDTH-1:0]   w_quo_nxt;
    logic [WIDTH-1:0]   w_div_res;
    logic               w_last;

    logic               w_load_out;
    logic [WIDTH-1:0]   w_out_res;
    logic               w_out_carry;
    logic               w_out_err;

    // ------------------------------------------------------------------------
    // Single-cycle datapath (also covers divide-by-zero and the reserved op)
    // ------------------------------------------------------------------------
    assign w_sum  = {1'b0, r_a} + {1'b0, r_b};
    assign w_div0 = (r_b == '0);
    assign w_iter = is_iterative(r_op) && !w_div0;

    always_comb begin
        w_sc_res   = '0;
        w_sc_carry = 1'b0;
        w_sc_err   = 1'b0;
        case (r_op)
            OP_AND:  w_sc_res = r_a & r_b;
            OP_XOR:  w_sc_res = r_a ^ r_b;
            OP_ADD: begin
                w_sc_res   = w_sum[WIDTH-1:0];
                w_sc_carry = w_sum[WIDTH];
            end
            OP_ROTL: begin
                w_sc_res   = {r_a[WIDTH-2:0], r_a[WIDTH-1]};
                w_sc_carry = r_a[WIDTH-1];
            end
            OP_SUB: begin
                w_sc_res   = r_a - r_b;
                w_sc_carry = (r_a >= r_b);
            end
            // Iterative ops arrive on this path only with a zero divisor.
            OP_MOD: begin
                w_sc_res = r_a;
                w_sc_err = 1'b1;
            end
            OP_DIV: begin
                w_sc_res = '1;
                w_sc_err = 1'b1;
            end
            default: begin
                w_sc_res = '0;
                w_sc_err = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Iterative divider step, shared by every ITER cycle
    // ------------------------------------------------------------------------
    alu_seq_divstep #(
        .WIDTH (WIDTH)
    ) u_divstep (
        .i_rem (r_rem),
        .i_quo (r_quo),
        .i_b   (r_b),
        .o_rem (w_rem_nxt),
        .o_quo (w_quo_nxt)
    );

    assign w_div_res = (r_op == OP_MOD) ? w_rem_nxt : w_quo_nxt;
    assign w_last    = (r_cnt == c_CNT_LAST);

    // ------------------------------------------------------------------------
    // Control FSM, operand latches and divider state
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_op    <= OP_AND;
            r_a     <= '0;
            r_b     <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op    <= op_e'(op);
                        r_a     <= in_a;
                        r_b     <= in_b;
                        r_state <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    if (w_iter) begin
                        r_rem   <= '0;
                        r_quo   <= r_a;
                        r_cnt   <= '0;
                        r_state <= c_ITER;
                    end else begin
                        r_state <= c_DONE;
                    end
                end
                c_ITER: begin
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output registers: updated only on the edge that enters DONE
    // ------------------------------------------------------------------------
    always_comb begin
        w_load_out  = 1'b0;
        w_out_res   = w_sc_res;
        w_out_carry = w_sc_carry;
        w_out_err   = w_sc_err;
        if ((r_state == c_EXEC) && !w_iter) begin
            w_load_out = 1'b1;
        end else if ((r_state == c_ITER) && w_last) begin
            w_load_out  = 1'b1;
            w_out_res   = w_div_res;
            w_out_carry = 1'b0;
            w_out_err   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b0;
            r_err    <= 1'b0;
        end else if (w_load_out) begin
            r_result <= w_out_res;
            r_carry  <= w_out_carry;
            r_zero   <= (w_out_res == '0);
            r_err    <= w_out_err;
        end
    end

    assign busy   = (r_state != c_IDLE);
    assign done   = (r_state == c_DONE);
    assign result = r_result;
    assign carry  = r_carry;
    assign zero   = r_zero;
    assign err    = r_err;

endmodule
`default_nettype wire
